morse_char_assembler: RTL and testbench

- Parametrised successor to the key-to-dot/dash front end.
- Times presses and gaps of a debounced Morse key in units of UNIT_CYCLES.
- Classifies each press as a dot or a dash, assembles up to MAX_SYMBOLS elements into a character code, and flags letter gaps and word gaps.
- Sits between the debouncer and the display/character consumer; live outputs feed the seven-segment path.

---
 rtl/morse_char_assembler.sv | 244 ++++++++++++++++++++++++
 tb/tb_morse_char_assembler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_assembler.sv
// Morse key timer and character assembler: classifies presses as dot/dash, builds
// character codes, and flags letter and word gaps. Optional ASCII ROM via MORSE_ASCII_EN.
module morse_char_assembler #(
    parameter int UNIT_CYCLES   = 10,
    parameter int GLITCH_CYCLES = 3,
    parameter int MAX_SYMBOLS   = 5,
    parameter int LEN_W         = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key,
    output logic                   dot,
    output logic                   dash,
    output logic [MAX_SYMBOLS-1:0] live_code,
    output logic [LEN_W-1:0]       live_len,
    output logic                   char_valid,
    output logic [MAX_SYMBOLS-1:0] char_code,
    output logic [LEN_W-1:0]       char_len,
    output logic                   char_err,
    output logic                   word_gap
`ifdef MORSE_ASCII_EN
    ,
    output logic [7:0]             ascii
`endif
);

    // One spare bit so a resumed gap (base + glitch + 1) never wraps before saturation.
    localparam int CNT_W = $clog2(7 * UNIT_CYCLES + 1) + 1;

    localparam logic [CNT_W-1:0] GLITCH_C    = CNT_W'(GLITCH_CYCLES);
    localparam logic [CNT_W-1:0] PRESS_MAX_C = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_C    = CNT_W'(3 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_MAX_C   = CNT_W'(7 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_SYMBOLS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] press_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_base;
    logic             err;
    logic             word_pend;

    logic             release_now;
    logic             press_glitch;
    logic             press_dash;
    logic             elem_accept;
    logic             adv_gap;
    logic [CNT_W-1:0] gap_prev;
    logic [CNT_W-1:0] gap_extra;
    logic [CNT_W-1:0] gap_adv;
    logic             letter_hit;
    logic             word_end;
    logic             word_hit;

    function automatic logic [CNT_W-1:0] sat_gap(input logic [CNT_W:0] v);
        if (v >= {1'b0, GAP_MAX_C})
            return GAP_MAX_C;
        return v[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_press(input logic [CNT_W-1:0] v);
        if (v >= PRESS_MAX_C)
            return PRESS_MAX_C;
        return v + CNT_ONE;
    endfunction

`ifdef MORSE_ASCII_EN
    // Codes are read first element at bit len-1, 1 = dash.
    function automatic logic [7:0] morse_ascii(input logic [LEN_W-1:0]       len,
                                               input logic [MAX_SYMBOLS-1:0] code,
                                               input logic                   bad);
        logic [11:0] sel;
        sel = {4'(len), 8'(code)};
        morse_ascii = 8'h3F;
        if (!bad) begin
            case (sel)
                {4'd1, 8'h00}: morse_ascii = 8'h45;
                {4'd1, 8'h01}: morse_ascii = 8'h54;
                {4'd2, 8'h01}: morse_ascii = 8'h41;
                {4'd2, 8'h00}: morse_ascii = 8'h49;
                {4'd2, 8'h03}: morse_ascii = 8'h4D;
                {4'd2, 8'h02}: morse_ascii = 8'h4E;
                {4'd3, 8'h04}: morse_ascii = 8'h44;
                {4'd3, 8'h06}: morse_ascii = 8'h47;
                {4'd3, 8'h05}: morse_ascii = 8'h4B;
                {4'd3, 8'h07}: morse_ascii = 8'h4F;
                {4'd3, 8'h02}: morse_ascii = 8'h52;
                {4'd3, 8'h00}: morse_ascii = 8'h53;
                {4'd3, 8'h01}: morse_ascii = 8'h55;
                {4'd3, 8'h03}: morse_ascii = 8'h57;
                {4'd4, 8'h08}: morse_ascii = 8'h42;
                {4'd4, 8'h0A}: morse_ascii = 8'h43;
                {4'd4, 8'h02}: morse_ascii = 8'h46;
                {4'd4, 8'h00}: morse_ascii = 8'h48;
                {4'd4, 8'h07}: morse_ascii = 8'h4A;
                {4'd4, 8'h04}: morse_ascii = 8'h4C;
                {4'd4, 8'h06}: morse_ascii = 8'h50;
                {4'd4, 8'h0D}: morse_ascii = 8'h51;
                {4'd4, 8'h01}: morse_ascii = 8'h56;
                {4'd4, 8'h09}: morse_ascii = 8'h58;
                {4'd4, 8'h0B}: morse_ascii = 8'h59;
                {4'd4, 8'h0C}: morse_ascii = 8'h5A;
                {4'd5, 8'h1F}: morse_ascii = 8'h30;
                {4'd5, 8'h0F}: morse_ascii = 8'h31;
                {4'd5, 8'h07}: morse_ascii = 8'h32;
                {4'd5, 8'h03}: morse_ascii = 8'h33;
                {4'd5, 8'h01}: morse_ascii = 8'h34;
                {4'd5, 8'h00}: morse_ascii = 8'h35;
                {4'd5, 8'h10}: morse_ascii = 8'h36;
                {4'd5, 8'h18}: morse_ascii = 8'h37;
                {4'd5, 8'h1C}: morse_ascii = 8'h38;
                {4'd5, 8'h1E}: morse_ascii = 8'h39;
                default:       morse_ascii = 8'h3F;
            endcase
        end
    endfunction
`endif

    // A glitch release folds its own cycles into the interrupted gap, so thresholds
    // are detected as crossings rather than exact hits.
    always_comb begin
        release_now  = (state == ST_PRESS) && !key;
        press_glitch = press_cnt < GLITCH_C;
        press_dash   = press_cnt >= PRESS_MAX_C;
        elem_accept  = release_now && !press_glitch;
        adv_gap      = 1'b0;
        gap_prev     = '0;
        gap_extra    = '0;
        if ((state == ST_GAP) && !key) begin
            adv_gap  = 1'b1;
            gap_prev = gap_cnt;
        end else if (release_now && press_glitch && (gap_base != '0)) begin
            adv_gap   = 1'b1;
            gap_prev  = gap_base;
            gap_extra = press_cnt;
        end
        gap_adv    = sat_gap({1'b0, gap_prev} + {1'b0, gap_extra} + {1'b0, CNT_ONE});
        letter_hit = adv_gap && (gap_prev < LETTER_C) && (gap_adv >= LETTER_C) &&
                     (live_len != '0);
        word_end   = adv_gap && (gap_adv == GAP_MAX_C);
        word_hit   = word_end && word_pend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            press_cnt  <= '0;
            gap_cnt    <= '0;
            gap_base   <= '0;
            err        <= 1'b0;
            word_pend  <= 1'b0;
            dot        <= 1'b0;
            dash       <= 1'b0;
            live_code  <= '0;
            live_len   <= '0;
            char_valid <= 1'b0;
            char_code  <= '0;
            char_len   <= '0;
            char_err   <= 1'b0;
            word_gap   <= 1'b0;
`ifdef MORSE_ASCII_EN
            ascii      <= 8'h00;
`endif
        end else begin
            dot        <= 1'b0;
            dash       <= 1'b0;
            char_valid <= 1'b0;
            word_gap   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (key) begin
                        state     <= ST_PRESS;
                        press_cnt <= CNT_ONE;
                        gap_base  <= '0;
                    end
                end
                ST_PRESS: begin
                    if (key) begin
                        press_cnt <= sat_press(press_cnt);
                    end else begin
                        press_cnt <= '0;
                        if (adv_gap) begin
                            gap_cnt <= word_end ? '0 : gap_adv;
                            state   <= word_end ? ST_IDLE : ST_GAP;
                        end else begin
                            gap_cnt <= CNT_ONE;
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (key) begin
                        state     <= ST_PRESS;
                        press_cnt <= CNT_ONE;
                        gap_base  <= gap_cnt;
                        gap_cnt   <= '0;
                    end else begin
                        gap_cnt <= word_end ? '0 : gap_adv;
                        if (word_end)
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (elem_accept) begin
                dot  <= !press_dash;
                dash <= press_dash;
                if (live_len >= MAX_LEN_C) begin
                    err <= 1'b1;
                end else begin
                    live_code <= (live_code << 1) | MAX_SYMBOLS'(press_dash);
                    live_len  <= live_len + LEN_W'(1);
                end
            end

            if (letter_hit) begin
                char_valid <= 1'b1;
                char_code  <= live_code;
                char_len   <= live_len;
                char_err   <= err;
`ifdef MORSE_ASCII_EN
                ascii      <= morse_ascii(live_len, live_code, err);
`endif
                live_code  <= '0;
                live_len   <= '0;
                err        <= 1'b0;
                word_pend  <= 1'b1;
            end

            if (word_hit) begin
                word_gap  <= 1'b1;
                word_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_char_assembler.sv
// Self-checking bench for morse_char_assembler: directed scenarios plus randomized
// key traffic compared against a press/gap level event model.
module tb_morse_char_assembler;

    localparam int U  = 10;
    localparam int GL = 3;
    localparam int MS = 5;
    localparam int LW = 4;

    localparam int K_DOT  = 0;
    localparam int K_DASH = 1;
    localparam int K_CHAR = 2;
    localparam int K_WORD = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          key = 1'b0;
    logic          dot, dash, char_valid, char_err, word_gap;
    logic [MS-1:0] live_code, char_code;
    logic [LW-1:0] live_len, char_len;
`ifdef MORSE_ASCII_EN
    logic [7:0]    ascii;
`endif

    typedef struct {
        int cyc;
        int kind;
        int code;
        int len;
        int err;
    } ev_t;

    ev_t obs[$];
    ev_t expq[$];
    int  p_len[$];
    int  g_len[$];
    int  ecyc;
    int  checks = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    morse_char_assembler #(
        .UNIT_CYCLES(U), .GLITCH_CYCLES(GL), .MAX_SYMBOLS(MS), .LEN_W(LW)
    ) dut (
        .clk(clk), .reset(reset), .key(key),
        .dot(dot), .dash(dash),
        .live_code(live_code), .live_len(live_len),
        .char_valid(char_valid), .char_code(char_code), .char_len(char_len),
        .char_err(char_err), .word_gap(word_gap)
`ifdef MORSE_ASCII_EN
        , .ascii(ascii)
`endif
    );

    // Drive one key sample, then record any pulses seen after that edge.
    task automatic run_cycle(input logic k);
        key = k;
        @(posedge clk);
        #1;
        if (dot)        obs.push_back('{ecyc, K_DOT,  int'(live_code), int'(live_len), 0});
        if (dash)       obs.push_back('{ecyc, K_DASH, int'(live_code), int'(live_len), 0});
        if (char_valid) obs.push_back('{ecyc, K_CHAR, int'(char_code), int'(char_len), int'(char_err)});
        if (word_gap)   obs.push_back('{ecyc, K_WORD, 0, 0, 0});
        ecyc++;
    endtask

    task automatic run_keys();
        ecyc = 0;
        obs.delete();
        for (int i = 0; i < p_len.size(); i++) begin
            repeat (p_len[i]) run_cycle(1'b1);
            repeat (g_len[i]) run_cycle(1'b0);
        end
    endtask

    // Event-level model: each press is classified by its length, then the following
    // low run is scanned arithmetically for the letter (3U) and word (7U) marks.
    function automatic void build_model();
        int s = 0, in_gap = 0, gend = 0, code = 0, len = 0, err = 0, pend = 0;
        expq.delete();
        for (int i = 0; i < p_len.size(); i++) begin
            int l, g, r, c0, prev, jl, jw, is_dash;
            l = p_len[i];
            g = g_len[i];
            r = s + l;
            if (l < GL) begin
                prev = in_gap ? gend : 0;
                c0   = in_gap ? ((gend + l + 1 > 7 * U) ? 7 * U : gend + l + 1) : 1;
            end else begin
                prev    = 0;
                c0      = 1;
                is_dash = (l >= 2 * U) ? 1 : 0;
                if (len < MS) begin
                    code = code * 2 + is_dash;
                    len++;
                end else begin
                    err = 1;
                end
                expq.push_back('{r, is_dash ? K_DASH : K_DOT, code, len, 0});
            end
            jl = (3 * U > c0) ? 3 * U - c0 : 0;
            if (prev < 3 * U && len > 0 && jl < g) begin
                expq.push_back('{r + jl, K_CHAR, code, len, err});
                code = 0; len = 0; err = 0; pend = 1;
            end
            jw = (7 * U > c0) ? 7 * U - c0 : 0;
            if (jw < g) begin
                if (pend != 0) begin
                    expq.push_back('{r + jw, K_WORD, 0, 0, 0});
                    pend = 0;
                end
                in_gap = 0;
            end else begin
                in_gap = 1;
                gend   = c0 + g - 1;
            end
            s = r + g;
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        key   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({dot, dash, char_valid, word_gap} !== 4'b0) begin failures++;
            $display("FAIL reset_pulses: got %b, expected 0000", {dot, dash, char_valid, word_gap}); end
        checks++; if (live_code !== '0 || live_len !== '0) begin failures++;
            $display("FAIL reset_live: got code=%0d len=%0d, expected 0 0", live_code, live_len); end
        checks++; if (char_code !== '0 || char_len !== '0 || char_err !== 1'b0) begin failures++;
            $display("FAIL reset_char: got code=%0d len=%0d err=%0d, expected 0 0 0", char_code, char_len, char_err); end
`ifdef MORSE_ASCII_EN
        checks++; if (ascii !== 8'h00) begin failures++;
            $display("FAIL reset_ascii: got %h, expected 00", ascii); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_glitch();
        p_len = '{2};
        g_len = '{100};
        run_keys();
        checks++; if (obs.size() !== 0) begin failures++;
            $display("FAIL glitch_events: got %0d events, expected 0", obs.size()); end
        checks++; if (live_len !== '0 || live_code !== '0 || char_len !== '0 || char_code !== '0 || char_err !== 1'b0) begin failures++;
            $display("FAIL glitch_outputs: got live_len=%0d char_len=%0d, expected 0 0", live_len, char_len); end
    endtask

    task automatic test_dot_letter();
        p_len = '{5};
        g_len = '{100};
        run_keys();
        checks++; if (obs.size() !== 3) begin failures++;
            $display("FAIL dot_events: got %0d events, expected 3", obs.size()); end
        else begin
            checks++; if (obs[0].kind !== K_DOT || obs[0].cyc !== 5 || obs[0].len !== 1 || obs[0].code !== 0) begin failures++;
                $display("FAIL dot_pulse: got kind=%0d cyc=%0d len=%0d, expected kind=0 cyc=5 len=1", obs[0].kind, obs[0].cyc, obs[0].len); end
            checks++; if (obs[1].kind !== K_CHAR || obs[1].cyc !== 34 || obs[1].code !== 0 || obs[1].len !== 1 || obs[1].err !== 0) begin failures++;
                $display("FAIL dot_char: got kind=%0d cyc=%0d code=%0d len=%0d err=%0d, expected 2 34 0 1 0", obs[1].kind, obs[1].cyc, obs[1].code, obs[1].len, obs[1].err); end
            checks++; if (obs[2].kind !== K_WORD || obs[2].cyc !== 74) begin failures++;
                $display("FAIL dot_word: got kind=%0d cyc=%0d, expected 3 74", obs[2].kind, obs[2].cyc); end
        end
        checks++; if (char_len !== 4'd1) begin failures++;
            $display("FAIL dot_char_hold: got len=%0d, expected 1", char_len); end
    endtask

    task automatic test_letter_a();
        p_len = '{5, 25};
        g_len = '{10, 100};
        run_keys();
        checks++; if (obs.size() !== 4) begin failures++;
            $display("FAIL a_events: got %0d events, expected 4", obs.size()); end
        else begin
            checks++; if (obs[1].kind !== K_DASH || obs[1].cyc !== 40 || obs[1].code !== 1 || obs[1].len !== 2) begin failures++;
                $display("FAIL a_dash: got kind=%0d cyc=%0d code=%0d len=%0d, expected 1 40 1 2", obs[1].kind, obs[1].cyc, obs[1].code, obs[1].len); end
            checks++; if (obs[2].kind !== K_CHAR || obs[2].cyc !== 69 || obs[2].code !== 1 || obs[2].len !== 2 || obs[2].err !== 0) begin failures++;
                $display("FAIL a_char: got kind=%0d cyc=%0d code=%0d len=%0d err=%0d, expected 2 69 1 2 0", obs[2].kind, obs[2].cyc, obs[2].code, obs[2].len, obs[2].err); end
        end
`ifdef MORSE_ASCII_EN
        checks++; if (ascii !== 8'h41) begin failures++;
            $display("FAIL a_ascii: got %h, expected 41", ascii); end
`endif
    endtask

    task automatic test_overflow();
        p_len.delete();
        g_len.delete();
        for (int k = 0; k < 6; k++) begin
            p_len.push_back(5);
            g_len.push_back(k < 5 ? 10 : 100);
        end
        run_keys();
        checks++; if (obs.size() !== 8) begin failures++;
            $display("FAIL ovf_events: got %0d events, expected 8", obs.size()); end
        else begin
            for (int k = 0; k < 6; k++) begin
                checks++; if (obs[k].kind !== K_DOT || obs[k].cyc !== 5 + 15 * k || obs[k].len !== (k < 5 ? k + 1 : 5)) begin failures++;
                    $display("FAIL ovf_dot%0d: got kind=%0d cyc=%0d len=%0d, expected 0 %0d %0d", k, obs[k].kind, obs[k].cyc, obs[k].len, 5 + 15 * k, (k < 5 ? k + 1 : 5)); end
            end
            checks++; if (obs[6].kind !== K_CHAR || obs[6].cyc !== 109 || obs[6].code !== 0 || obs[6].len !== 5 || obs[6].err !== 1) begin failures++;
                $display("FAIL ovf_char: got kind=%0d cyc=%0d code=%0d len=%0d err=%0d, expected 2 109 0 5 1", obs[6].kind, obs[6].cyc, obs[6].code, obs[6].len, obs[6].err); end
            checks++; if (obs[7].kind !== K_WORD || obs[7].cyc !== 149) begin failures++;
                $display("FAIL ovf_word: got kind=%0d cyc=%0d, expected 3 149", obs[7].kind, obs[7].cyc); end
        end
`ifdef MORSE_ASCII_EN
        checks++; if (ascii !== 8'h3F) begin failures++;
            $display("FAIL ovf_ascii: got %h, expected 3f", ascii); end
`endif
    endtask

    task automatic test_word_gap();
        p_len = '{5, 25};
        g_len = '{10, 170};
        run_keys();
        checks++; if (obs.size() !== 4) begin failures++;
            $display("FAIL word_events: got %0d events, expected 4 (one word gap only)", obs.size()); end
        else begin
            checks++; if (obs[2].kind !== K_CHAR || obs[2].cyc !== 69) begin failures++;
                $display("FAIL word_char: got kind=%0d cyc=%0d, expected 2 69", obs[2].kind, obs[2].cyc); end
            checks++; if (obs[3].kind !== K_WORD || obs[3].cyc !== 109) begin failures++;
                $display("FAIL word_pulse: got kind=%0d cyc=%0d, expected 3 109", obs[3].kind, obs[3].cyc); end
        end
        checks++; if (char_code !== 5'b00001 || char_len !== 4'd2) begin failures++;
            $display("FAIL word_char_hold: got code=%0d len=%0d, expected 1 2", char_code, char_len); end
    endtask

    task automatic test_reset_mid_press();
        ecyc = 0;
        obs.delete();
        repeat (5)  run_cycle(1'b1);
        repeat (10) run_cycle(1'b0);
        repeat (8)  run_cycle(1'b1);
        checks++; if (obs.size() !== 1 || live_len !== 4'd1) begin failures++;
            $display("FAIL rmid_dot: got events=%0d live_len=%0d, expected 1 1", obs.size(), live_len); end
        reset = 1'b1;
        repeat (3) run_cycle(1'b1);
        checks++; if ({dot, dash, char_valid, word_gap, char_err} !== 5'b0 || live_code !== '0 || live_len !== '0 || char_code !== '0 || char_len !== '0) begin failures++;
            $display("FAIL rmid_reset: got live_len=%0d char_len=%0d pulses=%b, expected all 0", live_len, char_len, {dot, dash, char_valid, word_gap}); end
        reset = 1'b0;
        obs.delete();
        repeat (80) run_cycle(1'b0);
        checks++; if (obs.size() !== 0 || live_len !== '0) begin failures++;
            $display("FAIL rmid_quiet: got events=%0d live_len=%0d, expected 0 0", obs.size(), live_len); end
        p_len = '{5, 25};
        g_len = '{10, 100};
        run_keys();
        checks++; if (obs.size() !== 4) begin failures++;
            $display("FAIL rmid_events: got %0d events, expected 4", obs.size()); end
        else begin
            checks++; if (obs[2].kind !== K_CHAR || obs[2].code !== 1 || obs[2].len !== 2) begin failures++;
                $display("FAIL rmid_char: got kind=%0d code=%0d len=%0d, expected 2 1 2", obs[2].kind, obs[2].code, obs[2].len); end
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            int n;
            p_len.delete();
            g_len.delete();
            for (int i = 0; i < 40; i++) begin
                int r1, r2;
                r1 = $urandom_range(0, 9);
                r2 = $urandom_range(0, 9);
                p_len.push_back(r1 < 2 ? $urandom_range(1, 2) :
                                r1 < 6 ? $urandom_range(3, 19) : $urandom_range(20, 35));
                g_len.push_back(r2 < 4 ? $urandom_range(1, 12)  :
                                r2 < 6 ? $urandom_range(26, 33) :
                                r2 < 8 ? $urandom_range(66, 73) : $urandom_range(13, 60));
            end
            g_len[39] = 100;
            build_model();
            run_keys();
            checks++; if (obs.size() !== expq.size()) begin failures++;
                $display("FAIL rand_count round %0d: got %0d events, expected %0d", round, obs.size(), expq.size()); end
            n = (obs.size() < expq.size()) ? obs.size() : expq.size();
            for (int i = 0; i < n; i++) begin
                checks++;
                if (obs[i].cyc !== expq[i].cyc || obs[i].kind !== expq[i].kind || obs[i].code !== expq[i].code ||
                    obs[i].len !== expq[i].len || obs[i].err !== expq[i].err) begin
                    failures++;
                    $display("FAIL rand_event round %0d idx %0d: got cyc=%0d kind=%0d code=%0d len=%0d err=%0d, expected cyc=%0d kind=%0d code=%0d len=%0d err=%0d",
                             round, i, obs[i].cyc, obs[i].kind, obs[i].code, obs[i].len, obs[i].err,
                             expq[i].cyc, expq[i].kind, expq[i].code, expq[i].len, expq[i].err);
                    break;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_dot_letter();
        test_letter_a();
        test_overflow();
        test_word_gap();
        test_reset_mid_press();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
